regfile_sb: RTL

- Parametrised, multi-read-port integer register file for the RV32 core, with write-to-read bypass and a per-register busy scoreboard.
- Sits between decode (read and issue) and writeback (write).
- Decode checks busy flags to detect RAW hazards on long-latency producers, such as loads, without a separate hazard unit.
- Register 0 is optionally hardwired to zero.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_scoreboard.sv | 48 ++++
 rtl/regfile_sb.sv | 93 +++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the regfile_sb register file slice.
package regfile_pkg;

  localparam int unsigned RF_XLEN  = 32;
  localparam int unsigned RF_NREGS = 32;

  function automatic int unsigned rf_aw(input int unsigned n);
    return $clog2(n);
  endfunction

  typedef logic [4:0] rf_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy flags with flush/issue/writeback priority and a registered busy count.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int unsigned NREGS    = RF_NREGS,
  parameter  int unsigned ZERO_REG = 1,
  localparam int unsigned AW       = rf_aw(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             issue_en,
  input  logic [AW-1:0]    issue_addr,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  output logic [NREGS-1:0] busy,
  output logic [AW:0]      busy_cnt
);

  logic [NREGS-1:0] busy_d;
  logic [AW:0]      cnt_d;

  // Issue is applied last so it overrides both flush and a same-cycle writeback.
  always_comb begin
    busy_d = busy;
    cnt_d  = '0;
    for (int unsigned r = 0; r < NREGS; r++) begin
      if (flush)
        busy_d[r] = 1'b0;
      else if (wr_en && (wr_addr == AW'(r)))
        busy_d[r] = 1'b0;
      if (issue_en && (issue_addr == AW'(r)) && !((ZERO_REG != 0) && (r == 0)))
        busy_d[r] = 1'b1;
      cnt_d = cnt_d + {{AW{1'b0}}, busy_d[r]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_d;
      busy_cnt <= cnt_d;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port integer register file with write bypass and busy scoreboard.
// Optional stored even parity per register under REGFILE_PARITY_EN.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int unsigned XLEN     = RF_XLEN,
  parameter  int unsigned NREGS    = RF_NREGS,
  parameter  int unsigned NREAD    = 2,
  parameter  int unsigned ZERO_REG = 1,
  localparam int unsigned AW       = rf_aw(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic [NREAD-1:0]      rd_busy,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  input  logic                  issue_en,
  input  logic [AW-1:0]         issue_addr,
  input  logic                  flush,
  output logic [AW:0]           busy_cnt,
  output logic [NREAD-1:0]      par_err
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic             wr_ok;
  logic [AW-1:0]    a;

  assign wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NREGS; r++)
        regs[r] <= '0;
    end else if (wr_ok) begin
      regs[wr_addr] <= wr_data;
    end
  end

`ifdef REGFILE_PARITY_EN
  logic [NREGS-1:0] par_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      par_q <= '0;
    else if (wr_ok)
      par_q[wr_addr] <= ^wr_data;
  end
`endif

  // Zero-register check precedes bypass so a dropped write to x0 is never forwarded.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    par_err = '0;
    a       = '0;
    for (int unsigned p = 0; p < NREAD; p++) begin
      a = rd_addr[p*AW +: AW];
      if ((ZERO_REG != 0) && (a == '0)) begin
        rd_data[p*XLEN +: XLEN] = '0;
        rd_busy[p]              = 1'b0;
      end else if (wr_en && (wr_addr == a)) begin
        rd_data[p*XLEN +: XLEN] = wr_data;
        rd_busy[p]              = 1'b0;
      end else begin
        rd_data[p*XLEN +: XLEN] = regs[a];
        rd_busy[p]              = busy[a];
`ifdef REGFILE_PARITY_EN
        par_err[p]              = ^{regs[a], par_q[a]};
`endif
      end
    end
  end

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .busy       (busy),
    .busy_cnt   (busy_cnt)
  );

endmodule
